// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg: shared definitions for the microwave cook timer.
//   state_e      - timer FSM states (IDLE=0, RUN=1, DONE=2)
//   bcd_time_t   - MM:SS cook time held as four BCD digits
//   bcd_dec()    - one-second decrement with the MM:SS borrow chain
package cook_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX          = 4'd9;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  // A zero digit wraps to its maximum and borrows from the next digit up.
  // sec_tens only has to be non-zero to decrement, so keypad entries such
  // as 00:90 count down as 00:89 rather than being normalised.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = BCD_MAX;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = BCD_MAX_SEC_TENS;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = BCD_MAX;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cook_timer_if.sv
// cook_timer_if: keypad / magnetron / display signals of the cook timer.
//   master - keypad and magnetron_control side: drives clear_, mag_on,
//            digit_valid, digit; observes the digits, time_zero, timer_done
//   slave  - cook_timer side
interface cook_timer_if;
  logic       clear_;
  logic       mag_on;
  logic       digit_valid;
  logic [3:0] digit;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       time_zero;
  logic       timer_done;

  modport master (
    output clear_, mag_on, digit_valid, digit,
    input  min_tens, min_ones, sec_tens, sec_ones, time_zero, timer_done
  );

  modport slave (
    input  clear_, mag_on, digit_valid, digit,
    output min_tens, min_ones, sec_tens, sec_ones, time_zero, timer_done
  );
endinterface

// File: rtl/cook_timer_tick_prescaler.sv
// cook_timer_tick_prescaler: divides clk down to one tick per second.
//   clk    - system clock
//   reset_ - asynchronous active-low reset
//   en     - count enable; while low the count is held at 0
//   tick   - high for the cycle in which the count sits at TICKS_PER_SEC-1
// TICKS_PER_SEC must be at least 2.
module cook_timer_tick_prescaler #(
  parameter int TICKS_PER_SEC = 100,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input  logic clk,
  input  logic reset_,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  // Combinational so the owner acts on the same edge the count wraps,
  // giving the first tick exactly TICKS_PER_SEC cycles after en rises.
  assign tick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cook_timer.sv
// cook_timer: MM:SS cook time entry and countdown for the microwave.
//   clk    - system clock, rising edge
//   reset_ - asynchronous active-low reset
//   bus    - cook_timer_if.slave:
//              clear_ (active-low keypad clear), mag_on, digit_valid, digit
//              -> min_tens, min_ones, sec_tens, sec_ones (registered BCD),
//                 time_zero (combinational), timer_done (registered pulse)
// Digits shift in from the right while idle, count down once per second
// while the magnetron is on, and timer_done pulses once when time runs out.
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int CNT_W         = $clog2(TICKS_PER_SEC)
) (
  input logic         clk,
  input logic         reset_,
  cook_timer_if.slave bus
);

  state_e    state;
  bcd_time_t cur;
  bcd_time_t cur_dec;
  logic      done_q;
  logic      time_zero;
  logic      run_en;
  logic      tick;

  assign time_zero = (cur == '0);
  assign cur_dec   = bcd_dec(cur);

  // The prescaler is gated by the same conditions that keep the FSM in
  // RUN, so a stop or a clear throws away the partial second on that edge.
  assign run_en = (state == ST_RUN) && bus.mag_on && bus.clear_;

  cook_timer_tick_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .CNT_W         (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .reset_ (reset_),
    .en     (run_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= ST_IDLE;
      cur    <= '0;
      done_q <= 1'b0;
    end else if (!bus.clear_) begin
      state  <= ST_IDLE;
      cur    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.mag_on) begin
            // Starting with no time goes straight to DONE so the
            // magnetron is shut off again immediately.
            if (time_zero) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else if (bus.digit_valid && (bus.digit <= BCD_MAX)) begin
            cur <= {cur.min_ones, cur.sec_tens, cur.sec_ones, bus.digit};
          end
        end
        ST_RUN: begin
          // Stopping pauses with the digits held; a coincident tick is lost.
          if (!bus.mag_on) begin
            state <= ST_IDLE;
          end else if (tick) begin
            cur <= cur_dec;
            if (cur_dec == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!bus.mag_on) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.min_tens   = cur.min_tens;
  assign bus.min_ones   = cur.min_ones;
  assign bus.sec_tens   = cur.sec_tens;
  assign bus.sec_ones   = cur.sec_ones;
  assign bus.time_zero  = time_zero;
  assign bus.timer_done = done_q;

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;
  localparam int TPS = 4;

  logic clk = 1'b0;
  logic reset_;

  cook_timer_if bus ();

  cook_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: cook time as a plain decimal number MMSS (0..9999),
  // mode 0=idle 1=running 2=done, cycles elapsed in the current second.
  int m_num;
  int m_mode;
  int m_pre;
  bit m_done;

  function automatic int sec_dec(input int n);
    int mm;
    int ss;
    mm = n / 100;
    ss = n % 100;
    if (ss > 0) ss = ss - 1;
    else begin
      mm = mm - 1;
      ss = 59;
    end
    return mm * 100 + ss;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'(n / 1000);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [15:0] shown();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic model_reset();
    m_num  = 0;
    m_mode = 0;
    m_pre  = 0;
    m_done = 1'b0;
  endtask

  task automatic model_edge(input logic clr_n, input logic mag, input logic dv,
                            input logic [3:0] d);
    m_done = 1'b0;
    if (!clr_n) begin
      m_num  = 0;
      m_mode = 0;
      m_pre  = 0;
    end else if (m_mode == 0) begin
      m_pre = 0;
      if (mag) begin
        if (m_num == 0) begin
          m_mode = 2;
          m_done = 1'b1;
        end else m_mode = 1;
      end else if (dv && d <= 4'd9) begin
        m_num = (m_num * 10 + int'(d)) % 10000;
      end
    end else if (m_mode == 1) begin
      if (!mag) begin
        m_mode = 0;
        m_pre  = 0;
      end else if (m_pre == TPS - 1) begin
        m_pre = 0;
        m_num = sec_dec(m_num);
        if (m_num == 0) begin
          m_mode = 2;
          m_done = 1'b1;
        end
      end else m_pre = m_pre + 1;
    end else begin
      m_pre = 0;
      if (!mag) m_mode = 0;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (!reset_) model_reset();
    else model_edge(bus.clear_, bus.mag_on, bus.digit_valid, bus.digit);
    #1;
    if (bus.timer_done) pulses++;
  endtask

  task automatic strobe(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit = d;
    clk_step();
    bus.digit_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear_ = 1'b0;
    clk_step();
    bus.clear_ = 1'b1;
  endtask

  task automatic load_time(input logic [15:0] v);
    do_clear();
    strobe(v[15:12]);
    strobe(v[11:8]);
    strobe(v[7:4]);
    strobe(v[3:0]);
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    model_reset();
    repeat (2) clk_step();
    checks++;
    if (shown() !== 16'h0000) begin
      errors++;
      $display("FAIL reset_digits: got %h expected 0000", shown());
    end
    checks++;
    if (bus.time_zero !== 1'b1 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: time_zero=%b timer_done=%b expected 1 0",
               bus.time_zero, bus.timer_done);
    end
    reset_ = 1'b1;
    clk_step();
    checks++;
    if (shown() !== 16'h0000 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got %h done=%b expected 0000 0", shown(), bus.timer_done);
    end
  endtask

  task automatic test_entry();
    strobe(4'd1);
    strobe(4'd3);
    strobe(4'd0);
    checks++;
    if (shown() !== 16'h0130) begin
      errors++;
      $display("FAIL entry_130: got %h expected 0130", shown());
    end
    checks++;
    if (bus.time_zero !== 1'b0 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL entry_flags: time_zero=%b timer_done=%b expected 0 0",
               bus.time_zero, bus.timer_done);
    end
  endtask

  task automatic test_expiry();
    load_time(16'h0002);
    pulses = 0;
    bus.mag_on = 1'b1;
    clk_step();
    repeat (3) clk_step();
    checks++;
    if (shown() !== 16'h0002) begin
      errors++;
      $display("FAIL expiry_pre_tick: got %h expected 0002", shown());
    end
    clk_step();
    checks++;
    if (shown() !== 16'h0001) begin
      errors++;
      $display("FAIL expiry_first_tick: got %h expected 0001", shown());
    end
    repeat (3) clk_step();
    clk_step();
    checks++;
    if (shown() !== 16'h0000 || bus.timer_done !== 1'b1) begin
      errors++;
      $display("FAIL expiry_edge: got %h done=%b expected 0000 1", shown(), bus.timer_done);
    end
    clk_step();
    checks++;
    if (bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL expiry_pulse_width: timer_done=%b expected 0", bus.timer_done);
    end
    repeat (4) clk_step();
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL expiry_pulse_count: got %0d expected 1", pulses);
    end
    bus.mag_on = 1'b0;
    clk_step();
    strobe(4'd7);
    checks++;
    if (shown() !== 16'h0007) begin
      errors++;
      $display("FAIL done_to_idle_entry: got %h expected 0007", shown());
    end
  endtask

  task automatic test_borrow();
    logic [15:0] ins [3];
    logic [15:0] exp [3];
    ins = '{16'h0100, 16'h1000, 16'h0090};
    exp = '{16'h0059, 16'h0959, 16'h0089};
    for (int i = 0; i < 3; i++) begin
      load_time(ins[i]);
      bus.mag_on = 1'b1;
      repeat (5) clk_step();
      checks++;
      if (shown() !== exp[i]) begin
        errors++;
        $display("FAIL borrow_%0d: got %h expected %h", i, shown(), exp[i]);
      end
      bus.mag_on = 1'b0;
      clk_step();
    end
  endtask

  task automatic test_pause();
    load_time(16'h0005);
    bus.mag_on = 1'b1;
    clk_step();
    clk_step();
    bus.digit_valid = 1'b1;
    bus.digit = 4'd8;
    clk_step();
    bus.digit_valid = 1'b0;
    repeat (3) clk_step();
    checks++;
    if (shown() !== 16'h0004) begin
      errors++;
      $display("FAIL pause_run: got %h expected 0004", shown());
    end
    bus.mag_on = 1'b0;
    repeat (10) clk_step();
    checks++;
    if (shown() !== 16'h0004) begin
      errors++;
      $display("FAIL pause_hold: got %h expected 0004", shown());
    end
    bus.mag_on = 1'b1;
    repeat (4) clk_step();
    checks++;
    if (shown() !== 16'h0004) begin
      errors++;
      $display("FAIL resume_partial_lost: got %h expected 0004", shown());
    end
    clk_step();
    checks++;
    if (shown() !== 16'h0003) begin
      errors++;
      $display("FAIL resume_tick: got %h expected 0003", shown());
    end
    bus.mag_on = 1'b0;
    clk_step();
  endtask

  task automatic test_clear_expiry();
    load_time(16'h0003);
    pulses = 0;
    bus.mag_on = 1'b1;
    repeat (12) clk_step();
    checks++;
    if (shown() !== 16'h0001) begin
      errors++;
      $display("FAIL clear_pre_expiry: got %h expected 0001", shown());
    end
    bus.clear_ = 1'b0;
    clk_step();
    bus.clear_ = 1'b1;
    checks++;
    if (shown() !== 16'h0000 || pulses != 0) begin
      errors++;
      $display("FAIL clear_at_expiry: got %h pulses=%0d expected 0000 0", shown(), pulses);
    end
    clk_step();
    checks++;
    if (bus.timer_done !== 1'b1) begin
      errors++;
      $display("FAIL zero_start_pulse: timer_done=%b expected 1", bus.timer_done);
    end
    clk_step();
    checks++;
    if (bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_start_width: timer_done=%b expected 0", bus.timer_done);
    end
    bus.mag_on = 1'b0;
    clk_step();
  endtask

  task automatic test_limits_and_reset();
    do_clear();
    strobe(4'd1);
    strobe(4'd2);
    strobe(4'd3);
    strobe(4'd4);
    strobe(4'd5);
    checks++;
    if (shown() !== 16'h2345) begin
      errors++;
      $display("FAIL five_digits: got %h expected 2345", shown());
    end
    strobe(4'hA);
    checks++;
    if (shown() !== 16'h2345) begin
      errors++;
      $display("FAIL invalid_digit: got %h expected 2345", shown());
    end
    bus.mag_on = 1'b1;
    repeat (2) clk_step();
    #2;
    reset_ = 1'b0;
    model_reset();
    #1;
    checks++;
    if (shown() !== 16'h0000 || bus.time_zero !== 1'b1 || bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_run: got %h tz=%b done=%b expected 0000 1 0",
               shown(), bus.time_zero, bus.timer_done);
    end
    clk_step();
    reset_ = 1'b1;
    clk_step();
    checks++;
    if (bus.timer_done !== 1'b1) begin
      errors++;
      $display("FAIL pulse_before_reset: timer_done=%b expected 1", bus.timer_done);
    end
    #2;
    reset_ = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.timer_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_done: timer_done=%b expected 0", bus.timer_done);
    end
    clk_step();
    reset_ = 1'b1;
    bus.mag_on = 1'b0;
    clk_step();
  endtask

  task automatic test_random();
    do_clear();
    for (int i = 0; i < 1500; i++) begin
      bus.clear_ = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 24) == 0) bus.mag_on = ~bus.mag_on;
      bus.digit_valid = ($urandom_range(0, 3) == 0);
      bus.digit = 4'($urandom_range(0, 11));
      clk_step();
      checks++;
      if (shown() !== to_bcd(m_num) || bus.time_zero !== (m_num == 0) ||
          bus.timer_done !== m_done) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h tz=%b done=%b expected %h tz=%b done=%b",
                 i, shown(), bus.time_zero, bus.timer_done, to_bcd(m_num),
                 (m_num == 0), m_done);
      end
    end
    bus.clear_ = 1'b1;
    bus.mag_on = 1'b0;
    bus.digit_valid = 1'b0;
    clk_step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset_ = 1'b0;
    bus.clear_ = 1'b1;
    bus.mag_on = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit = 4'd0;
    model_reset();
    test_reset();
    test_entry();
    test_expiry();
    test_borrow();
    test_pause();
    test_clear_expiry();
    test_limits_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Upstream neighbour of magnetron_control. Holds the cook time as four BCD digits (MM:SS) entered from the keypad.
- Counts down once per second while the magnetron is on.
- Produces timer_done, a one-cycle pulse that magnetron_control consumes to shut the magnetron off.
- Digit outputs also feed the display driver.

Parameters:
- TICKS_PER_SEC, default 100: clk cycles per one second of cook time. Kept small for simulation; set to the board clock frequency in synthesis.
- CNT_W, default $clog2(TICKS_PER_SEC): prescaler counter width.

Ports:
- clk  input  1  system clock, rising edge
- reset_  input  1  asynchronous, active-low reset
- clear_  input  1  active-low keypad clear; synchronous effect
- mag_on  input  1  magnetron state from magnetron_control; enables countdown
- digit_valid  input  1  one-cycle strobe: keypad digit available
- digit  input  4  keypad digit value (BCD)
- min_tens  output  4  BCD minutes tens
- min_ones  output  4  BCD minutes ones
- sec_tens  output  4  BCD seconds tens
- sec_ones  output  4  BCD seconds ones
- time_zero  output  1  combinational: all four digits are 0
- timer_done  output  1  registered one-cycle pulse: cook time expired

Behaviour:
- Reset (reset_=0, async): all digits 0, prescaler 0, FSM IDLE, timer_done 0. Therefore time_zero=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when mag_on=1 and time_zero=0.
  - IDLE -> DONE when mag_on=1 and time_zero=1. timer_done pulses on that transition edge, so the oven never runs with no time.
  - RUN -> DONE when the decrement reaches 00:00.
  - RUN -> IDLE when mag_on=0 (stop or door open). Digits are held, giving pause/resume.
  - DONE -> IDLE when mag_on=0.
- Digit entry happens only in IDLE with digit_valid=1 and digit<=9.
  - Shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
  - The old min_tens is discarded.
  - digit>9 is ignored. digit_valid in RUN or DONE is ignored.
- Prescaler:
  - Runs only in RUN. Held at 0 in IDLE and DONE.
  - On reaching TICKS_PER_SEC-1 it wraps to 0 and issues a tick.
  - The first decrement occurs TICKS_PER_SEC cycles after entering RUN.
  - Leaving RUN discards any partial second.
- Decrement (BCD borrow chain, on tick):
  - sec_ones 0 -> 9 and borrows.
  - sec_tens 0 -> 5 and borrows.
  - min_ones 0 -> 9 and borrows.
  - min_tens decrements.
  - Entered sec_tens values above 5 (e.g. 00:90) count down normally: 00:90 -> 00:89.
- Expiry:
  - On the tick edge that takes 00:01 -> 00:00, digits become 0, FSM enters DONE and timer_done=1 for exactly that following cycle.
  - Exactly one timer_done pulse per run.
- clear_=0 has priority over everything except reset:
  - Digits and prescaler go to 0 and the FSM goes to IDLE.
  - No timer_done pulse is generated, even if a tick or expiry coincides.
- Simultaneous digit_valid and clear_=0: clear wins.
- Simultaneous tick and mag_on falling: mag_on=0 wins, no decrement.
- Reset mid-run: everything zeroed immediately, timer_done drops asynchronously.
- All outputs except time_zero are registered.

Decomposition:
- Shared header (microwave_defs): FSM state encodings (IDLE=0, RUN=1, DONE=2), BCD_MAX_SEC_TENS=5, BCD_MAX=9.
- Sub-module tick_prescaler (clk, reset_, en, tick), parameterised by TICKS_PER_SEC.
- Digit shift and borrow chain stay in cook_timer.

Test Plan (TICKS_PER_SEC=4):
- Reset, then digits 1,3,0 strobed -> digits 0,1,3,0 (01:30), time_zero=0, timer_done=0.
- Load 00:02, mag_on=1 held -> 00:01 four cycles after RUN entry, then 00:00 four cycles later. timer_done high exactly 1 cycle on that edge, then DONE until mag_on=0.
- Load 01:00, run one tick -> 00:59. Load 10:00, run one tick -> 09:59. Load 00:90, run one tick -> 00:89.
- Load 00:05, mag_on=1 for 6 cycles, then 0 for 10 cycles -> holds 00:04. mag_on=1 again -> 00:03 after 4 more cycles. Digits strobed while mag_on=1 are ignored.
- Load 00:03, run, assert clear_=0 on the expiry-edge cycle -> digits 00:00, IDLE, timer_done never asserted. With digits 00:00, mag_on=1 -> timer_done one-cycle pulse next edge.
- Strobe 5 digits 1,2,3,4,5 -> 23:45. digit=4'hA strobed -> ignored. reset_=0 mid-RUN -> all outputs 0 without a clock edge.
